// File: rtl/seq_gen_0110_if.sv
// Serial pattern transmitter interface: control/pattern inputs and serial stream outputs.
// master drives load/pat_in/start/repeat_n/stop and observes the stream.
// slave (the generator) consumes the controls and drives out/out_vld/sof/busy/done.
interface seq_gen_0110_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             load;
    logic [WIDTH-1:0] pat_in;
    logic             start;
    logic [CNT_W-1:0] repeat_n;
    logic             stop;
    logic             out;
    logic             out_vld;
    logic             sof;
    logic             busy;
    logic             done;

    modport master (
        output load, pat_in, start, repeat_n, stop,
        input  out, out_vld, sof, busy, done
    );

    modport slave (
        input  load, pat_in, start, repeat_n, stop,
        output out, out_vld, sof, busy, done
    );
endinterface

// File: rtl/seq_gen_0110.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern MSB-first, N frames with GAP idle cycles between.
// Latency: start sampled at edge k, MSB with sof on out after edge k; all outputs registered.
// No backpressure: stream is free-running once started; stop ends the run at the next frame boundary.
// Ports: clk, rst (async active-low), bus (slave modport: load/pat_in/start/repeat_n/stop in,
//        out/out_vld/sof/busy/done out).
module seq_gen_0110 #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b0110,
    parameter int               GAP     = 1,
    parameter int               CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_gen_0110_if.slave  bus
);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BIT_W-1:0] MSB_IDX  = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pattern, pattern_n;
    logic [BIT_W-1:0] bit_idx, bit_n;
    logic [CNT_W-1:0] frame_cnt, frame_n, frame_nx;
    logic [CNT_W-1:0] rep_q, rep_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic             stop_q, stop_n;
    logic             last_frame;

    always_comb begin
        state_n    = state;
        pattern_n  = pattern;
        bit_n      = bit_idx;
        frame_n    = frame_cnt;
        frame_nx   = frame_cnt + 1'b1;
        rep_n      = rep_q;
        gap_n      = gap_cnt;
        stop_n     = stop_q;
        last_frame = 1'b0;

        case (state)
            S_IDLE: begin
                // load takes priority; a simultaneous start is dropped
                if (bus.load) begin
                    pattern_n = bus.pat_in;
                end else if (bus.start) begin
                    state_n = S_SEND;
                    bit_n   = MSB_IDX;
                    frame_n = '0;
                    rep_n   = bus.repeat_n;
                    stop_n  = 1'b0;
                end
            end
            S_SEND: begin
                // stop is sticky; it only takes effect once the frame's LSB is out
                stop_n = stop_q | bus.stop;
                if (bit_idx == '0) begin
                    frame_n    = frame_nx;
                    // rep_q == 0 means continuous; frame_nx then just wraps
                    last_frame = stop_n || ((rep_q != '0) && (frame_nx == rep_q));
                    if (last_frame) begin
                        state_n = S_DONE;
                    end else if (GAP == 0) begin
                        bit_n = MSB_IDX;
                    end else begin
                        state_n = S_GAP;
                        gap_n   = '0;
                    end
                end else begin
                    bit_n = bit_idx - 1'b1;
                end
            end
            S_GAP: begin
                // a stop arriving during the gap is already at a frame boundary
                if (stop_q || bus.stop) begin
                    stop_n  = 1'b1;
                    state_n = S_DONE;
                end else if (gap_cnt == GAP_LAST) begin
                    state_n = S_SEND;
                    bit_n   = MSB_IDX;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                stop_n  = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pattern   <= PATTERN;
            bit_idx   <= '0;
            frame_cnt <= '0;
            rep_q     <= '0;
            gap_cnt   <= '0;
            stop_q    <= 1'b0;
        end else begin
            state     <= state_n;
            pattern   <= pattern_n;
            bit_idx   <= bit_n;
            frame_cnt <= frame_n;
            rep_q     <= rep_n;
            gap_cnt   <= gap_n;
            stop_q    <= stop_n;
        end
    end

    // Outputs are registered from the next state so they line up with it;
    // pattern only changes while staying in IDLE, so it is stable here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out     <= 1'b0;
            bus.out_vld <= 1'b0;
            bus.sof     <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.out     <= (state_n == S_SEND) && pattern[bit_n];
            bus.out_vld <= (state_n == S_SEND);
            bus.sof     <= (state_n == S_SEND) && (bit_n == MSB_IDX);
            bus.busy    <= (state_n != S_IDLE);
            bus.done    <= (state_n == S_DONE);
        end
    end
endmodule

// File: tb/tb_seq_gen_0110.sv
// Bench for seq_gen_0110: scoreboard of per-cycle expected output vectors
// {out, out_vld, sof, busy, done}, filled from a small model when a run is started
// and popped on every falling clock edge.
module tb_seq_gen_0110;
    localparam int W   = 4;
    localparam int GP  = 1;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_gen_0110_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    seq_gen_0110 #(
        .WIDTH(W), .PATTERN(4'b0110), .GAP(GP), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] q[$];
    logic [W-1:0] cur_pat = 4'b0110;

    function automatic logic [4:0] obs();
        return {bus.out, bus.out_vld, bus.sof, bus.busy, bus.done};
    endfunction

    // Model of one run: frames back-to-back with GP idle cycles, done, then one idle.
    task automatic push_run(input logic [W-1:0] p, input int nframes);
        for (int f = 0; f < nframes; f++) begin
            for (int i = W - 1; i >= 0; i--)
                q.push_back({p[i], 1'b1, (i == W - 1), 1'b1, 1'b0});
            if (f < nframes - 1)
                for (int g = 0; g < GP; g++) q.push_back(5'b00010);
        end
        q.push_back(5'b00011);
        q.push_back(5'b00000);
    endtask

    task automatic test_reset();
        bus.load = 0; bus.pat_in = '0; bus.start = 0; bus.repeat_n = '0; bus.stop = 0;
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== 5'b00000) begin
                n_bad++;
                $display("FAIL reset cyc %0d: got %b want 00000", i, obs());
            end
        end
        rst = 1;
        @(negedge clk);
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_idle: got %b want 00000", obs());
        end
    endtask

    task automatic test_single();
        logic [4:0] e;
        bus.start = 1; bus.repeat_n = 8'd1;
        push_run(4'b0110, 1);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL single cyc %0d: got %b want %b", i, obs(), e);
            end
            bus.start = 0;
        end
    endtask

    task automatic test_repeat3();
        logic [4:0] e;
        int busy_cnt = 0, sof_cnt = 0;
        bus.start = 1; bus.repeat_n = 8'd3;
        push_run(4'b0110, 3);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front();
            busy_cnt += int'(bus.busy);
            sof_cnt  += int'(bus.sof);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL repeat3 cyc %0d: got %b want %b", i, obs(), e);
            end
            bus.start = 0;
        end
        n_cmp++;
        if (busy_cnt != 3 * W + 2 * GP + 1) begin
            n_bad++;
            $display("FAIL repeat3_busy: got %0d want %0d", busy_cnt, 3 * W + 2 * GP + 1);
        end
        n_cmp++;
        if (sof_cnt != 3) begin
            n_bad++;
            $display("FAIL repeat3_sof: got %0d want 3", sof_cnt);
        end
    endtask

    task automatic test_load();
        logic [4:0] e;
        bus.load = 1; bus.pat_in = 4'b1011;
        @(negedge clk);
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_bad++;
            $display("FAIL load_idle: got %b want 00000", obs());
        end
        bus.load = 0;
        cur_pat = 4'b1011;
        bus.start = 1; bus.repeat_n = 8'd1;
        push_run(cur_pat, 1);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL load_run cyc %0d: got %b want %b", i, obs(), e);
            end
            bus.start = 0;
        end
        // load and start together: pattern taken, no transmission
        bus.load = 1; bus.start = 1; bus.pat_in = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== 5'b00000) begin
                n_bad++;
                $display("FAIL load_start cyc %0d: got %b want 00000", i, obs());
            end
            bus.load = 0; bus.start = 0;
        end
        cur_pat = 4'b1100;
        bus.start = 1;
        push_run(cur_pat, 1);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL load_new cyc %0d: got %b want %b", i, obs(), e);
            end
            bus.start = 0;
        end
    endtask

    task automatic test_stop();
        logic [4:0] e;
        bus.start = 1; bus.repeat_n = 8'd0;
        push_run(cur_pat, 3);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL stop cyc %0d: got %b want %b", i, obs(), e);
            end
            bus.start = 0;
            // frame 3 starts at sample 2*(W+GP); bit 2 shows one cycle later
            bus.stop = (i == 2 * (W + GP) + 1);
        end
        bus.stop = 0;
    endtask

    task automatic test_midreset();
        logic [4:0] e;
        bus.start = 1; bus.repeat_n = 8'd2;
        push_run(4'b1100, 2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL midrst_pre cyc %0d: got %b want %b", i, obs(), e);
            end
            bus.start = 0;
        end
        q.delete();
        #2 rst = 0;
        #1;
        n_cmp++;
        if (obs() !== 5'b00000) begin
            n_bad++;
            $display("FAIL midrst_async: got %b want 00000", obs());
        end
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== 5'b00000) begin
                n_bad++;
                $display("FAIL midrst_nodone cyc %0d: got %b want 00000", i, obs());
            end
        end
        cur_pat = 4'b0110;
        bus.start = 1; bus.repeat_n = 8'd1;
        push_run(cur_pat, 1);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL midrst_post cyc %0d: got %b want %b", i, obs(), e);
            end
            bus.start = 0;
        end
    endtask

    task automatic test_start_held();
        logic [4:0] e;
        // each run is W send + done + one idle cycle, so 20 held edges start 4 runs
        bus.start = 1; bus.repeat_n = 8'd1; bus.pat_in = 4'b1111;
        for (int r = 0; r < 4; r++) push_run(cur_pat, 1);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL start_held cyc %0d: got %b want %b", i, obs(), e);
            end
            if (i == 19) bus.start = 0;
            // load only while the next edge sees a busy state
            bus.load = (i < 19) && e[1];
        end
        bus.load = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat3();
        test_load();
        test_stop();
        test_midreset();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
